// File: rtl/mult_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter_pkg
// Description : Shared defaults, latency expression and tag slot type for the
//               multiplier-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_share_arbiter_pkg;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_WIDTH_A   = 8;
  localparam int DEF_WIDTH_B   = 8;
  localparam int DEF_WIDTH_OUT = 16;
  localparam int DEF_STAGE     = 5;

  // One operand-capture register plus STAGE product registers.
  function automatic int latency_of(input int stage);
    return stage + 1;
  endfunction

  localparam int DEF_LATENCY = latency_of(DEF_STAGE);

  // Requester id width; NREQ of an instance must fit in this many bits.
  localparam int ID_W = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_slot_t;

endpackage
`default_nettype wire

// File: rtl/mult_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter_if
// Description : Request/response bundle between requesters and the shared
//               multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_share_arbiter_if
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH_A   = DEF_WIDTH_A,
  parameter int WIDTH_B   = DEF_WIDTH_B,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH_A-1:0] req_a;
  logic [NREQ*WIDTH_B-1:0] req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [WIDTH_OUT-1:0]    rsp_data;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter_mult.sv
`default_nettype none
// ============================================================================
// Module      : Multiplier_bam
// Description : Pipelined multiplier with global pipeline enable. Operands are
//               captured on the first enabled edge, the product then walks
//               through STAGE registers: STAGE+1 enabled edges in total.
// Revision    : 1.0 - initial release
// ============================================================================
module Multiplier_bam #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int WIDTH_OUT = 16,
  parameter int STAGE     = 5,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pip_en,
  input  logic [WIDTH_A-1:0]   a,
  input  logic [WIDTH_B-1:0]   b,
  output logic [WIDTH_OUT-1:0] p
);

  logic [WIDTH_A-1:0]          a_q;
  logic [WIDTH_B-1:0]          b_q;
  logic signed [WIDTH_A:0]     a_ext;
  logic signed [WIDTH_B:0]     b_ext;
  logic signed [WIDTH_OUT-1:0] prod;
  logic [WIDTH_OUT-1:0]        pipe [STAGE];

  // One extra bit lets the same multiply serve signed and unsigned modes.
  assign a_ext = (SIGNED != 0) ? {a_q[WIDTH_A-1], a_q} : {1'b0, a_q};
  assign b_ext = (SIGNED != 0) ? {b_q[WIDTH_B-1], b_q} : {1'b0, b_q};
  // Only the low WIDTH_OUT bits are kept, so multiply at that width.
  assign prod  = $signed(WIDTH_OUT'(a_ext)) * $signed(WIDTH_OUT'(b_ext));
  assign p     = pipe[STAGE-1];

  // Operand capture and product pipeline, frozen when pip_en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int s = 0; s < STAGE; s++) pipe[s] <= '0;
    end else if (pip_en) begin
      a_q     <= a;
      b_q     <= b;
      pipe[0] <= prod;
      for (int s = 1; s < STAGE; s++) pipe[s] <= pipe[s-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Round-robin sharing of one pipelined multiplier among NREQ
//               requesters. A tag pipeline tracks the owner of each in-flight
//               product; a stalled result at the tail freezes everything.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH_A   = DEF_WIDTH_A,
  parameter int WIDTH_B   = DEF_WIDTH_B,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int STAGE     = DEF_STAGE
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus
);

  localparam int              LATENCY = latency_of(STAGE);
  localparam int              CNT_W   = $clog2(LATENCY + 1);
  localparam logic [ID_W:0]   NREQ_W  = (ID_W + 1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  logic               advance;
  logic               issue;
  logic               found;
  logic               rsp_fire;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W:0]      cand_sum;
  logic [CNT_W-1:0]   inflight;
  logic [NREQ-1:0]    ready_vec;
  logic [NREQ-1:0]    rsp_vec;
  logic [WIDTH_A-1:0] a_sel;
  logic [WIDTH_B-1:0] b_sel;
  tag_slot_t          tags [LATENCY];
  tag_slot_t          tail;

  assign tail     = tags[LATENCY-1];
  // Only an unaccepted result at the multiplier output can stall the unit.
  assign advance  = ~(tail.valid & ~bus.rsp_ready[tail.id]);
  assign issue    = advance & found & ~rst;
  assign rsp_fire = tail.valid & bus.rsp_ready[tail.id] & ~rst;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand_sum >= NREQ_W) cand_sum = cand_sum - NREQ_W;
      if (!found && bus.req_valid[cand_sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand_sum[ID_W-1:0];
      end
    end
  end

  // One-hot accept for the winner and one-hot result valid for the tail owner.
  always_comb begin
    ready_vec = '0;
    rsp_vec   = '0;
    if (issue) ready_vec[winner] = 1'b1;
    if (tail.valid && !rst) rsp_vec[tail.id] = 1'b1;
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_vec;
  assign bus.busy      = (inflight != '0) & ~rst;

  assign a_sel = bus.req_a[winner*WIDTH_A +: WIDTH_A];
  assign b_sel = bus.req_b[winner*WIDTH_B +: WIDTH_B];

  // Priority pointer moves past the winner on every issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (winner == LAST_ID) ? '0 : winner + 1'b1;
    end
  end

  // Owner tags travel alongside the products; bubbles fill idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) tags[s] <= '0;
    end else if (advance) begin
      tags[0] <= '{valid: issue, id: winner};
      for (int s = 1; s < LATENCY; s++) tags[s] <= tags[s-1];
    end
  end

  // Outstanding operation count: issue adds, response handshake removes.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, rsp_fire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  Multiplier_bam #(
    .WIDTH_A   (WIDTH_A),
    .WIDTH_B   (WIDTH_B),
    .WIDTH_OUT (WIDTH_OUT),
    .STAGE     (STAGE),
    .SIGNED    (1)
  ) u_mult (
    .clk    (clk),
    .rst_n  (~rst),
    .pip_en (advance),
    .a      (a_sel),
    .b      (b_sel),
    .p      (bus.rsp_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Directed and randomized self-checking bench for the
//               multiplier-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;

  mult_share_arbiter_if #(.NREQ(4), .WIDTH_A(8), .WIDTH_B(8), .WIDTH_OUT(16)) bus ();

  mult_share_arbiter #(
    .NREQ(4), .WIDTH_A(8), .WIDTH_B(8), .WIDTH_OUT(16), .STAGE(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_ops(input logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3);
    bus.req_a = {a3, a2, a1, a0};
    bus.req_b = {b3, b2, b1, b0};
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b0000;
    set_ops(8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4);
    tick();
    tick();
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0000", bus.rsp_data); end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    set_ops(8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd3, 8'd0, 8'd0);
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    for (int c = 1; c < 6; c++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.rsp_valid !== 4'b0000) begin
        errors++; $display("FAIL single_wait cycle=%0d busy=%b rsp_valid=%b exp busy=1 rsp_valid=0000", c, bus.busy, bus.rsp_valid);
      end
      tick();
    end
    checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'd15) begin
      errors++; $display("FAIL single_result rsp_valid=%b data=%0d exp 0100/15", bus.rsp_valid, $signed(bus.rsp_data));
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL single_drain busy=%b rsp_valid=%b exp 0/0000", bus.busy, bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int         exp_id [5];
    int         exp_d [5];
    int         n;
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{0, 1, 2, 3, 0};
    exp_d  = '{-15, 35, -1, 16384, -15};
    do_reset();
    set_ops(-8'sd5, 8'sd3, -8'sd5, -8'sd7, -8'sd1, 8'sd1, -8'sd128, -8'sd128);
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      checks++;
      if (bus.req_ready !== exp_g[g]) begin
        errors++; $display("FAIL rr_grant idx=%0d got=%b exp=%b", g, bus.req_ready, exp_g[g]);
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid !== 4'b0000 && n < 5) begin
        checks++;
        if (bus.rsp_valid !== (4'b0001 << exp_id[n]) || bus.rsp_data !== 16'(exp_d[n])) begin
          errors++; $display("FAIL rr_result idx=%0d rsp_valid=%b data=%0d exp id=%0d data=%0d", n, bus.rsp_valid, $signed(bus.rsp_data), exp_id[n], exp_d[n]);
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", n); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ops(8'sd2, 8'sd3, -8'sd4, 8'sd5, 8'sd7, -8'sd7, 8'sd9, 8'sd9);
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0111;
    #1;
    tick();
    tick();
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'd6) begin
      errors++; $display("FAIL bp_first rsp_valid=%b data=%0d exp 0001/6", bus.rsp_valid, $signed(bus.rsp_data));
    end
    tick();
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || dut.advance !== 1'b0 || bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 16'hFFEC) begin
        errors++; $display("FAIL bp_stall cycle=%0d req_ready=%b advance=%b rsp_valid=%b data=%0d exp 0000/0/0010/-20", c, bus.req_ready, dut.advance, bus.rsp_valid, $signed(bus.rsp_data));
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 4'b1111;
    #1;
    checks++;
    if (dut.advance !== 1'b1) begin errors++; $display("FAIL bp_release advance=%b exp=1", dut.advance); end
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'hFFCF) begin
      errors++; $display("FAIL bp_third rsp_valid=%b data=%0d exp 0100/-49", bus.rsp_valid, $signed(bus.rsp_data));
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bp_drain rsp_valid=%b busy=%b exp 0000/0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    do_reset();
    set_ops(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    bus.req_valid = 4'b1111;
    tick();
    tick();
    tick();
    tick();
    bus.req_valid = 4'b0000;
    #1;
    checks++;
    if (dut.inflight !== 3'd4) begin errors++; $display("FAIL mid_inflight got=%0d exp=4", dut.inflight); end
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_in_reset req_ready=%b rsp_valid=%b busy=%b exp 0000/0000/0", bus.req_ready, bus.rsp_valid, bus.busy);
    end
    tick();
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    #1;
    checks++;
    if (dut.inflight !== 3'd0 || dut.ptr !== 2'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_after inflight=%0d ptr=%0d busy=%b exp 0/0/0", dut.inflight, dut.ptr, bus.busy);
    end
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid !== 4'b0000) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale got=%0d cycles exp=0", stale); end
  endtask

  task automatic test_random();
    exp_t              q[$];
    exp_t              e;
    int                issued;
    int                cyc;
    int                owner;
    logic signed [7:0] a8;
    logic signed [7:0] b8;
    do_reset();
    issued = 0;
    cyc    = 0;
    while ((issued < 500 || q.size() != 0) && cyc < 8000) begin
      bus.req_valid = (issued < 500) ? 4'($urandom) : 4'b0000;
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      bus.rsp_ready = ~4'($urandom & $urandom);
      #1;
      checks++;
      if ($countones(bus.req_ready) > 1 || (bus.req_ready & ~bus.req_valid) != 4'b0000) begin
        errors++; $display("FAIL rand_grant cycle=%0d req_ready=%b req_valid=%b", cyc, bus.req_ready, bus.req_valid);
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.req_ready[i] && bus.req_valid[i]) begin
          a8 = bus.req_a[i*8 +: 8];
          b8 = bus.req_b[i*8 +: 8];
          q.push_back('{id: i, data: 16'(int'(a8) * int'(b8))});
          issued++;
        end
      end
      if (bus.rsp_valid != 4'b0000) begin
        owner = 0;
        for (int i = 0; i < 4; i++) if (bus.rsp_valid[i]) owner = i;
        checks++;
        if ($countones(bus.rsp_valid) != 1) begin
          errors++; $display("FAIL rand_onehot cycle=%0d rsp_valid=%b", cyc, bus.rsp_valid);
        end
        if (bus.rsp_ready[owner]) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL rand_extra cycle=%0d rsp_valid=%b with empty scoreboard", cyc, bus.rsp_valid);
          end else begin
            e = q.pop_front();
            if (e.id != owner || bus.rsp_data !== e.data) begin
              errors++; $display("FAIL rand_result cycle=%0d id=%0d data=%h exp id=%0d data=%h", cyc, owner, bus.rsp_data, e.id, e.data);
            end
          end
        end
      end
      checks++;
      if (dut.inflight > 3'd6) begin errors++; $display("FAIL rand_inflight cycle=%0d got=%0d max=6", cyc, dut.inflight); end
      tick();
      cyc++;
    end
    checks++;
    if (issued != 500 || q.size() != 0) begin
      errors++; $display("FAIL rand_complete issued=%0d pending=%0d exp 500/0", issued, q.size());
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
